// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator evaluation pipeline:
// sequencer states, error codes, stage indices and key decoder button indices.
package calc_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START0,
    S_WAIT0,
    S_START1,
    S_WAIT1,
    S_START2,
    S_WAIT2,
    S_DONE,
    S_ERROR
  } seq_state_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_EMPTY   = 3'd1,
    ERR_BUILD   = 3'd2,
    ERR_POSTFIX = 3'd3,
    ERR_EVAL    = 3'd4,
    ERR_TIMEOUT = 3'd5
  } err_code_t;

  localparam int STG_BUILD   = 0;
  localparam int STG_POSTFIX = 1;
  localparam int STG_EVAL    = 2;
  localparam int NUM_STAGES  = 3;

  // Button indices shared with the key decoder.
  localparam int BTN_DIGIT0 = 0;
  localparam int BTN_DOT    = 10;
  localparam int BTN_ADD    = 11;
  localparam int BTN_SUB    = 12;
  localparam int BTN_MUL    = 13;
  localparam int BTN_DIV    = 14;
  localparam int BTN_LPAREN = 15;
  localparam int BTN_RPAREN = 16;
  localparam int BTN_SIN    = 17;
  localparam int BTN_PI     = 18;

  function automatic logic [NUM_STAGES-1:0] start_mask(input seq_state_t s);
    case (s)
      S_START0: start_mask = 3'b001;
      S_START1: start_mask = 3'b010;
      S_START2: start_mask = 3'b100;
      default:  start_mask = 3'b000;
    endcase
  endfunction

  function automatic logic is_running(input seq_state_t s);
    return s inside {S_START0, S_WAIT0, S_START1, S_WAIT1, S_START2, S_WAIT2};
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage cycle watchdog. expired pulses on the cycle in which the
// counter steps to timeout-1, so the abort lands timeout cycles after the start pulse.
module stage_watchdog #(
  parameter int timeout = 4096
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(timeout);
  localparam logic [W-1:0] LAST = W'(timeout - 2);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/eval_sequencer.sv
// Top-level controller: runs build -> postfix -> evaluate on an eval press,
// locks the editor while busy, guards each stage with a watchdog and latches status.
module eval_sequencer
  import calc_pkg::*;
#(
  parameter int depth   = 20,
  parameter int timeout = 4096
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       eval,
  input  logic                       keyAct,
  input  logic                       clr,
  input  logic [$clog2(depth+1)-1:0] tokenCount,
  input  logic [2:0]                 stgDone,
  input  logic [2:0]                 stgErr,
  output logic [2:0]                 stgStart,
  output logic                       stgFlush,
  output logic                       editLock,
  output logic                       busy,
  output logic                       resultValid,
  output logic [2:0]                 errCode
);

  seq_state_t state, state_n;
  err_code_t  err_q, err_n;
  logic       eval_q, eval_rise;
  logic       flush_n;
  logic       wd_clear, wd_enable, wd_expired;

  assign eval_rise = eval & ~eval_q;
  assign wd_clear  = state inside {S_START0, S_START1, S_START2};
  assign wd_enable = state inside {S_WAIT0, S_WAIT1, S_WAIT2};

  stage_watchdog #(.timeout(timeout)) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_n = state;
    err_n   = err_q;
    flush_n = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (eval_rise) begin
          if (tokenCount == '0) begin
            state_n = S_ERROR;
            err_n   = ERR_EMPTY;
          end else begin
            state_n = S_START0;
          end
        end else if (keyAct) begin
          state_n = S_IDLE;
        end
      end
      S_START0: state_n = S_WAIT0;
      S_START1: state_n = S_WAIT1;
      S_START2: state_n = S_WAIT2;
      S_WAIT0: begin
        if (stgDone[STG_BUILD]) begin
          state_n = stgErr[STG_BUILD] ? S_ERROR : S_START1;
          err_n   = ERR_BUILD;
        end else if (wd_expired) begin
          state_n = S_ERROR;
          err_n   = ERR_TIMEOUT;
          flush_n = 1'b1;
        end
      end
      S_WAIT1: begin
        if (stgDone[STG_POSTFIX]) begin
          state_n = stgErr[STG_POSTFIX] ? S_ERROR : S_START2;
          err_n   = ERR_POSTFIX;
        end else if (wd_expired) begin
          state_n = S_ERROR;
          err_n   = ERR_TIMEOUT;
          flush_n = 1'b1;
        end
      end
      S_WAIT2: begin
        if (stgDone[STG_EVAL]) begin
          state_n = stgErr[STG_EVAL] ? S_ERROR : S_DONE;
          err_n   = ERR_EVAL;
        end else if (wd_expired) begin
          state_n = S_ERROR;
          err_n   = ERR_TIMEOUT;
          flush_n = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (clr) begin
      state_n = S_IDLE;
      flush_n = 1'b1;
    end
    // The error code is only visible while sitting in ERROR.
    if (state_n != S_ERROR) err_n = ERR_NONE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      err_q       <= ERR_NONE;
      eval_q      <= 1'b0;
      stgStart    <= '0;
      stgFlush    <= 1'b0;
      editLock    <= 1'b0;
      busy        <= 1'b0;
      resultValid <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the same pre-edge values.
      state       <= state_n;
      err_q       <= err_n;
      eval_q      <= eval;
      stgStart    <= start_mask(state_n);
      stgFlush    <= flush_n;
      editLock    <= is_running(state_n);
      busy        <= is_running(state_n);
      resultValid <= (state_n == S_DONE);
    end
  end

  assign errCode = err_q;

endmodule
